// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: holds the fetch PC, selects the next PC, fills IF/ID, and checks
// branch predictions resolving in MEM (flush, BTB update, statistics counters).
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        btb_pred_taken,
    input  logic [31:0] btb_pred_target,
    input  logic        mem_valid,
    input  logic        mem_is_branch,
    input  logic [31:0] mem_pc,
    input  logic        mem_actual_taken,
    input  logic [31:0] mem_actual_target,
    input  logic        mem_pred_taken,
    input  logic [31:0] mem_pred_target,
    output logic [31:0] pc_if,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic        if_id_pred_taken,
    output logic [31:0] if_id_pred_target,
    output logic        flush,
    output logic        btb_upd_en,
    output logic [31:0] btb_upd_pc,
    output logic [31:0] btb_upd_target,
    output logic        btb_upd_taken,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    logic [31:0] pc_q, pc_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic        if_id_pred_taken_q, if_id_pred_taken_d;
    logic [31:0] if_id_pred_target_q, if_id_pred_target_d;
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    logic        resolution;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic [31:0] fallthru_pc;
    logic [31:0] seq_pc;

    // A taken/taken pair still mispredicts when the predicted target was wrong.
    always_comb begin
        resolution  = mem_valid & mem_is_branch;
        mispredict  = (mem_pred_taken != mem_actual_taken) ||
                      (mem_pred_taken && mem_actual_taken &&
                       (mem_pred_target != mem_actual_target));
        fallthru_pc = mem_pc + 32'd4;
        correct_pc  = mem_actual_taken ? {mem_actual_target[31:2], 2'b00}
                                       : {fallthru_pc[31:2], 2'b00};
        seq_pc      = pc_q + 32'd4;
    end

    always_comb begin
        flush          = resolution & mispredict;
        btb_upd_en     = resolution;
        btb_upd_pc     = mem_pc;
        btb_upd_target = mem_actual_target;
        btb_upd_taken  = mem_actual_taken;
    end

    // Next PC: flush beats stall, stall beats prediction, prediction beats PC+4.
    always_comb begin
        pc_d = seq_pc;
        if (flush) begin
            pc_d = correct_pc;
        end else if (stall_if) begin
            pc_d = pc_q;
        end else if (btb_pred_taken) begin
            pc_d = btb_pred_target;
        end
    end

    always_comb begin
        if_id_valid_d       = if_id_valid_q;
        if_id_pc_d          = if_id_pc_q;
        if_id_pred_taken_d  = if_id_pred_taken_q;
        if_id_pred_target_d = if_id_pred_target_q;
        if (flush) begin
            if_id_valid_d = 1'b0;
        end else if (!stall_if) begin
            if_id_valid_d       = 1'b1;
            if_id_pc_d          = pc_q;
            if_id_pred_taken_d  = btb_pred_taken;
            if_id_pred_target_d = btb_pred_target;
        end
    end

    // Statistics counters saturate rather than wrap and ignore the fetch stall.
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (resolution && (branch_cnt_q != 32'hFFFF_FFFF)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (flush && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q                <= RESET_PC;
            if_id_valid_q       <= 1'b0;
            if_id_pc_q          <= 32'd0;
            if_id_pred_taken_q  <= 1'b0;
            if_id_pred_target_q <= 32'd0;
            branch_cnt_q        <= 32'd0;
            mispred_cnt_q       <= 32'd0;
        end else begin
            pc_q                <= pc_d;
            if_id_valid_q       <= if_id_valid_d;
            if_id_pc_q          <= if_id_pc_d;
            if_id_pred_taken_q  <= if_id_pred_taken_d;
            if_id_pred_target_q <= if_id_pred_target_d;
            branch_cnt_q        <= branch_cnt_d;
            mispred_cnt_q       <= mispred_cnt_d;
        end
    end

    always_comb begin
        pc_if             = pc_q;
        if_id_valid       = if_id_valid_q;
        if_id_pc          = if_id_pc_q;
        if_id_pred_taken  = if_id_pred_taken_q;
        if_id_pred_target = if_id_pred_target_q;
        branch_cnt        = branch_cnt_q;
        mispred_cnt       = mispred_cnt_q;
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios plus randomized traffic against a cycle model.
module tb_fetch_pc_gen;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_if;
    logic        btb_pred_taken;
    logic [31:0] btb_pred_target;
    logic        mem_valid;
    logic        mem_is_branch;
    logic [31:0] mem_pc;
    logic        mem_actual_taken;
    logic [31:0] mem_actual_target;
    logic        mem_pred_taken;
    logic [31:0] mem_pred_target;
    logic [31:0] pc_if;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic        if_id_pred_taken;
    logic [31:0] if_id_pred_target;
    logic        flush;
    logic        btb_upd_en;
    logic [31:0] btb_upd_pc;
    logic [31:0] btb_upd_target;
    logic        btb_upd_taken;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_v;
    logic [31:0] m_ifpc;
    logic        m_ift;
    logic [31:0] m_iftgt;
    logic [31:0] m_bc;
    logic [31:0] m_mc;

    fetch_pc_gen #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .stall_if(stall_if),
        .btb_pred_taken(btb_pred_taken), .btb_pred_target(btb_pred_target),
        .mem_valid(mem_valid), .mem_is_branch(mem_is_branch), .mem_pc(mem_pc),
        .mem_actual_taken(mem_actual_taken), .mem_actual_target(mem_actual_target),
        .mem_pred_taken(mem_pred_taken), .mem_pred_target(mem_pred_target),
        .pc_if(pc_if), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_pred_taken(if_id_pred_taken), .if_id_pred_target(if_id_pred_target),
        .flush(flush), .btb_upd_en(btb_upd_en), .btb_upd_pc(btb_upd_pc),
        .btb_upd_target(btb_upd_target), .btb_upd_taken(btb_upd_taken),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit m_resolve();
        return mem_valid && mem_is_branch;
    endfunction

    function automatic bit m_flush();
        bit wrong;
        wrong = (mem_pred_taken != mem_actual_taken) ||
                (mem_pred_taken && mem_actual_taken && mem_pred_target != mem_actual_target);
        return m_resolve() && wrong;
    endfunction

    function automatic logic [31:0] m_correct_pc();
        logic [31:0] t;
        t = mem_actual_taken ? mem_actual_target : mem_pc + 32'd4;
        return t & 32'hFFFF_FFFC;
    endfunction

    task automatic drive_idle();
        rst = 1'b0; stall_if = 1'b0;
        btb_pred_taken = 1'b0; btb_pred_target = 32'd0;
        mem_valid = 1'b0; mem_is_branch = 1'b0; mem_pc = 32'd0;
        mem_actual_taken = 1'b0; mem_actual_target = 32'd0;
        mem_pred_taken = 1'b0; mem_pred_target = 32'd0;
    endtask

    task automatic drive_branch(input logic [31:0] pc, input logic pt, input logic [31:0] ptg,
                                input logic at, input logic [31:0] atg);
        mem_valid = 1'b1; mem_is_branch = 1'b1; mem_pc = pc;
        mem_pred_taken = pt; mem_pred_target = ptg;
        mem_actual_taken = at; mem_actual_target = atg;
    endtask

    // Advance one clock: model computes its next state from the stable inputs, then the
    // DUT edge happens, then we return at the following negedge for sampling.
    task automatic tick();
        logic [31:0] n_pc, n_ifpc, n_iftgt, n_bc, n_mc;
        logic n_v, n_ift, fl, rs;
        fl = m_flush(); rs = m_resolve();
        n_pc = m_pc; n_v = m_v; n_ifpc = m_ifpc; n_ift = m_ift; n_iftgt = m_iftgt;
        n_bc = (rs && m_bc != 32'hFFFF_FFFF) ? m_bc + 1 : m_bc;
        n_mc = (fl && m_mc != 32'hFFFF_FFFF) ? m_mc + 1 : m_mc;
        if (rst) begin
            n_pc = RST_PC; n_v = 0; n_ifpc = 0; n_ift = 0; n_iftgt = 0; n_bc = 0; n_mc = 0;
        end else if (fl) begin
            n_pc = m_correct_pc(); n_v = 0;
        end else if (!stall_if) begin
            n_v = 1; n_ifpc = m_pc; n_ift = btb_pred_taken; n_iftgt = btb_pred_target;
            n_pc = btb_pred_taken ? btb_pred_target : m_pc + 32'd4;
        end
        @(posedge clk);
        m_pc = n_pc; m_v = n_v; m_ifpc = n_ifpc; m_ift = n_ift; m_iftgt = n_iftgt;
        m_bc = n_bc; m_mc = n_mc;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (pc_if !== 32'h100) begin errors++; $display("FAIL reset_pc got %h exp %h", pc_if, 32'h100); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if_id_valid); end
        checks++; if (if_id_pc !== 32'd0) begin errors++; $display("FAIL reset_if_id_pc got %h exp 0", if_id_pc); end
        checks++; if (if_id_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got %b exp 0", if_id_pred_taken); end
        checks++; if (if_id_pred_target !== 32'd0) begin errors++; $display("FAIL reset_pred_target got %h exp 0", if_id_pred_target); end
        checks++; if (branch_cnt !== 32'd0) begin errors++; $display("FAIL reset_branch_cnt got %h exp 0", branch_cnt); end
        checks++; if (mispred_cnt !== 32'd0) begin errors++; $display("FAIL reset_mispred_cnt got %h exp 0", mispred_cnt); end
    endtask

    task automatic test_sequential();
        tick();
        checks++; if (pc_if !== 32'h104) begin errors++; $display("FAIL seq_pc1 got %h exp 104", pc_if); end
        checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL first_fetch_valid got %b exp 1", if_id_valid); end
        checks++; if (if_id_pc !== 32'h100) begin errors++; $display("FAIL first_fetch_pc got %h exp 100", if_id_pc); end
        tick();
        checks++; if (pc_if !== 32'h108) begin errors++; $display("FAIL seq_pc2 got %h exp 108", pc_if); end
        checks++; if (if_id_pc !== 32'h104) begin errors++; $display("FAIL seq_if_id_pc2 got %h exp 104", if_id_pc); end
        checks++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            errors++; $display("FAIL seq_counters got %h/%h exp 0/0", branch_cnt, mispred_cnt);
        end
    endtask

    task automatic test_prediction();
        btb_pred_taken = 1'b1; btb_pred_target = 32'h200;
        tick();
        btb_pred_taken = 1'b0; btb_pred_target = 32'd0;
        checks++; if (pc_if !== 32'h200) begin errors++; $display("FAIL pred_pc got %h exp 200", pc_if); end
        checks++; if (if_id_pc !== 32'h108) begin errors++; $display("FAIL pred_if_id_pc got %h exp 108", if_id_pc); end
        checks++; if (if_id_pred_taken !== 1'b1) begin errors++; $display("FAIL pred_taken_latched got %b exp 1", if_id_pred_taken); end
        checks++; if (if_id_pred_target !== 32'h200) begin errors++; $display("FAIL pred_target_latched got %h exp 200", if_id_pred_target); end
        checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL pred_no_bubble got %b exp 1", if_id_valid); end
    endtask

    task automatic test_mispredict();
        drive_branch(32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mis_flush got %b exp 1", flush); end
        checks++; if (btb_upd_en !== 1'b1 || btb_upd_taken !== 1'b1) begin
            errors++; $display("FAIL mis_upd_en_taken got %b%b exp 11", btb_upd_en, btb_upd_taken);
        end
        checks++; if (btb_upd_pc !== 32'h40 || btb_upd_target !== 32'h80) begin
            errors++; $display("FAIL mis_upd_pc_target got %h/%h exp 40/80", btb_upd_pc, btb_upd_target);
        end
        tick();
        drive_idle();
        checks++; if (pc_if !== 32'h80) begin errors++; $display("FAIL mis_redirect got %h exp 80", pc_if); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL mis_bubble got %b exp 0", if_id_valid); end
        checks++; if (mispred_cnt !== 32'd1 || branch_cnt !== 32'd1) begin
            errors++; $display("FAIL mis_counters got %h/%h exp 1/1", mispred_cnt, branch_cnt);
        end
        #1;
        checks++; if (flush !== 1'b0 || btb_upd_en !== 1'b0) begin
            errors++; $display("FAIL idle_no_flush got %b%b exp 00", flush, btb_upd_en);
        end
        tick();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h80) begin
            errors++; $display("FAIL mis_refetch got %b/%h exp 1/80", if_id_valid, if_id_pc);
        end
    endtask

    task automatic test_flush_over_stall();
        stall_if = 1'b1;
        drive_branch(32'h40, 1'b1, 32'h300, 1'b0, 32'h300);
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL stall_flush got %b exp 1", flush); end
        tick();
        drive_idle();
        checks++; if (pc_if !== 32'h44) begin errors++; $display("FAIL stall_redirect got %h exp 44", pc_if); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL stall_bubble got %b exp 0", if_id_valid); end
        checks++; if (mispred_cnt !== 32'd2 || branch_cnt !== 32'd2) begin
            errors++; $display("FAIL stall_counters got %h/%h exp 2/2", mispred_cnt, branch_cnt);
        end
        tick();
    endtask

    task automatic test_correct_pred_stall();
        logic [31:0] hold_pc, hold_ifpc;
        logic        hold_v;
        hold_pc = pc_if; hold_ifpc = if_id_pc; hold_v = if_id_valid;
        stall_if = 1'b1;
        drive_branch(32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
        #1;
        checks++; if (flush !== 1'b0 || btb_upd_en !== 1'b1) begin
            errors++; $display("FAIL good_pred_flush_upd got %b%b exp 01", flush, btb_upd_en);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            mem_valid = 1'b0; mem_is_branch = 1'b0;
            checks++; if (pc_if !== hold_pc || if_id_pc !== hold_ifpc || if_id_valid !== hold_v) begin
                errors++; $display("FAIL stall_hold%0d got %h/%h/%b exp %h/%h/%b", i, pc_if, if_id_pc, if_id_valid, hold_pc, hold_ifpc, hold_v);
            end
        end
        checks++; if (branch_cnt !== 32'd3 || mispred_cnt !== 32'd2) begin
            errors++; $display("FAIL good_pred_counters got %h/%h exp 3/2", branch_cnt, mispred_cnt);
        end
        drive_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            stall_if = ($urandom_range(0, 3) == 0);
            btb_pred_taken = ($urandom_range(0, 2) == 0);
            btb_pred_target = $urandom() & 32'hFFFF_FFFC;
            mem_valid = ($urandom_range(0, 1) == 1);
            mem_is_branch = ($urandom_range(0, 3) != 0);
            mem_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            mem_actual_taken = $urandom_range(0, 1);
            mem_actual_target = $urandom();
            mem_pred_taken = $urandom_range(0, 1);
            mem_pred_target = ($urandom_range(0, 1) == 1) ? mem_actual_target : $urandom();
            #1;
            checks++; if (flush !== m_flush() || btb_upd_en !== m_resolve()) begin
                errors++; $display("FAIL rnd_comb%0d got %b%b exp %b%b", i, flush, btb_upd_en, m_flush(), m_resolve());
            end
            checks++; if (btb_upd_pc !== mem_pc || btb_upd_target !== mem_actual_target || btb_upd_taken !== mem_actual_taken) begin
                errors++; $display("FAIL rnd_upd%0d got %h/%h/%b", i, btb_upd_pc, btb_upd_target, btb_upd_taken);
            end
            tick();
            checks++; if (pc_if !== m_pc || if_id_valid !== m_v) begin
                errors++; $display("FAIL rnd_pc%0d got %h/%b exp %h/%b", i, pc_if, if_id_valid, m_pc, m_v);
            end
            checks++; if (branch_cnt !== m_bc || mispred_cnt !== m_mc) begin
                errors++; $display("FAIL rnd_cnt%0d got %h/%h exp %h/%h", i, branch_cnt, mispred_cnt, m_bc, m_mc);
            end
            if (m_v) begin
                checks++; if (if_id_pc !== m_ifpc || if_id_pred_taken !== m_ift || if_id_pred_target !== m_iftgt) begin
                    errors++; $display("FAIL rnd_ifid%0d got %h/%b/%h exp %h/%b/%h", i, if_id_pc, if_id_pred_taken, if_id_pred_target, m_ifpc, m_ift, m_iftgt);
                end
            end
        end
        drive_idle();
    endtask

    task automatic test_saturation_and_reset();
        force dut.mispred_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.mispred_cnt_q;
        m_mc = 32'hFFFF_FFFF;
        drive_branch(32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
        tick();
        checks++; if (mispred_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_mispred got %h exp ffffffff", mispred_cnt); end
        checks++; if (pc_if !== 32'h80) begin errors++; $display("FAIL sat_redirect got %h exp 80", pc_if); end
        rst = 1'b1;
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rst_flush_comb got %b exp 1", flush); end
        tick();
        drive_idle();
        checks++; if (pc_if !== RST_PC) begin errors++; $display("FAIL rst_over_flush_pc got %h exp %h", pc_if, RST_PC); end
        checks++; if (mispred_cnt !== 32'd0 || branch_cnt !== 32'd0 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL rst_over_flush_state got %h/%h/%b exp 0/0/0", mispred_cnt, branch_cnt, if_id_valid);
        end
    endtask

    initial begin
        m_pc = 0; m_v = 0; m_ifpc = 0; m_ift = 0; m_iftgt = 0; m_bc = 0; m_mc = 0;
        drive_idle();
        @(negedge clk);
        test_reset();
        test_sequential();
        test_prediction();
        test_mispredict();
        test_flush_over_stall();
        test_correct_pred_stall();
        test_random();
        test_saturation_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
